// File: rtl/lcd_panel_seq.sv
// ---------------------------------------------------------------------------
// lcd_panel_seq
//
// Power-up/shutdown sequencer and test-pattern scheduler for the 480x272 RGB
// LCD path. Gates the pixel timing generator, drives DISP and backlight in a
// frame-counted order, and selects the active test pattern. Pattern changes
// are applied only at frame boundaries.
//
// Ports
//   PixelClk     in   pixel clock, all logic on its rising edge
//   nRST         in   asynchronous active-low reset
//   enable       in   level, 1 = panel requested on
//   frame_start  in   one-cycle pulse at the first clock of each frame
//   next_req     in   one-cycle pulse, request the next pattern
//   auto_en      in   level, 1 = advance every AUTO_FRAMES frames
//   timing_en    out  timing generator counter enable
//   LCD_DISP     out  panel display enable
//   LCD_BL       out  backlight enable
//   pattern_sel  out  active pattern index
//   ready        out  1 while the panel is fully on (RUN)
// ---------------------------------------------------------------------------
module lcd_panel_seq #(
    parameter int PWR_FRAMES   = 2,
    parameter int BL_FRAMES    = 3,
    parameter int OFF_FRAMES   = 2,
    parameter int AUTO_FRAMES  = 60,
    parameter int NUM_PATTERNS = 4
) (
    input  logic       PixelClk,
    input  logic       nRST,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       next_req,
    input  logic       auto_en,
    output logic       timing_en,
    output logic       LCD_DISP,
    output logic       LCD_BL,
    output logic [1:0] pattern_sel,
    output logic       ready
);

    typedef enum logic [2:0] {
        S_OFF,
        S_PWR_WAIT,
        S_BL_WAIT,
        S_RUN,
        S_SHUTDOWN
    } state_t;

    // Terminal counts: the frame_start seen with the counter at these values
    // is the one that completes the phase.
    localparam logic [7:0] PWR_LAST  = 8'(PWR_FRAMES - 1);
    localparam logic [7:0] BL_LAST   = 8'(BL_FRAMES - 1);
    localparam logic [7:0] OFF_LAST  = 8'(OFF_FRAMES - 1);
    localparam logic [7:0] AUTO_LAST = 8'(AUTO_FRAMES - 1);
    localparam logic [1:0] PAT_LAST  = 2'(NUM_PATTERNS - 1);

    state_t     state, state_nxt;
    logic [7:0] fc, fc_nxt;
    logic [7:0] ac, ac_nxt;
    logic       pend, pend_nxt;
    logic [1:0] pat_nxt;
    logic       adv;
    logic       te_nxt, disp_nxt, bl_nxt, rdy_nxt;

    // Next-state, counters and output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case/if tree leaves it unassigned (which would infer a latch).
        state_nxt = state;
        fc_nxt    = fc;
        ac_nxt    = ac;
        pend_nxt  = pend;
        pat_nxt   = pattern_sel;
        adv       = 1'b0;
        te_nxt    = 1'b0;
        disp_nxt  = 1'b0;
        bl_nxt    = 1'b0;
        rdy_nxt   = 1'b0;

        case (state)
            S_OFF: begin
                if (enable) state_nxt = S_PWR_WAIT;
            end
            S_PWR_WAIT: begin
                if (!enable)                          state_nxt = S_SHUTDOWN;
                else if (frame_start && fc == PWR_LAST) state_nxt = S_BL_WAIT;
            end
            S_BL_WAIT: begin
                if (!enable)                          state_nxt = S_SHUTDOWN;
                else if (frame_start && fc == BL_LAST)  state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable) state_nxt = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                // enable is deliberately ignored until OFF is reached.
                if (frame_start && fc == OFF_LAST) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase

        // Frame counter restarts on every phase change so each phase counts
        // its own frames from zero.
        if (state_nxt != state)
            fc_nxt = 8'd0;
        else if (frame_start &&
                 (state == S_PWR_WAIT || state == S_BL_WAIT || state == S_SHUTDOWN))
            fc_nxt = fc + 8'd1;

        // One advance per frame boundary, whatever combination of pending
        // request, same-cycle request and auto timeout triggered it.
        adv = (state == S_RUN) && frame_start &&
              (pend || next_req || (auto_en && ac == AUTO_LAST));

        if (state != S_RUN || adv) pend_nxt = 1'b0;
        else if (next_req)         pend_nxt = 1'b1;

        if (state != S_RUN || !auto_en || adv) ac_nxt = 8'd0;
        else if (frame_start)                  ac_nxt = ac + 8'd1;

        if (adv) pat_nxt = (pattern_sel == PAT_LAST) ? 2'd0 : pattern_sel + 2'd1;

        // NOTE: outputs are decoded from the next state and registered, so
        // they change on the same edge as the state and never glitch.
        case (state_nxt)
            S_PWR_WAIT, S_BL_WAIT, S_SHUTDOWN: begin
                te_nxt   = 1'b1;
                disp_nxt = 1'b1;
            end
            S_RUN: begin
                te_nxt   = 1'b1;
                disp_nxt = 1'b1;
                bl_nxt   = 1'b1;
                rdy_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state       <= S_OFF;
            fc          <= 8'd0;
            ac          <= 8'd0;
            pend        <= 1'b0;
            pattern_sel <= 2'd0;
            timing_en   <= 1'b0;
            LCD_DISP    <= 1'b0;
            LCD_BL      <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state       <= state_nxt;
            fc          <= fc_nxt;
            ac          <= ac_nxt;
            pend        <= pend_nxt;
            pattern_sel <= pat_nxt;
            timing_en   <= te_nxt;
            LCD_DISP    <= disp_nxt;
            LCD_BL      <= bl_nxt;
            ready       <= rdy_nxt;
        end
    end

endmodule
